// File: rtl/ntt_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sched
// Purpose  : Stage scheduler and write-back sequencer for a pipelined radix-2
//            Cooley-Tukey NTT butterfly. Walks all LOGN stages over an
//            N = 2^LOGN coefficient RAM, issuing one operand pair per cycle,
//            draining the butterfly pipeline between stages, and writing
//            results back in place.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW     : coefficient / twiddle width
//   LOGN   : log2 of transform length (LOGN >= 2)
//   BF_LAT : butterfly latency, en -> valid, in cycles
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle request to run a full transform
//   busy / done / err   : run status, completion pulse, sticky orphan error
//   rd_en, rd_addr_x/y  : coefficient RAM read port (1-cycle read latency)
//   rd_data_x/y         : coefficient RAM read data
//   tw_addr / tw_data   : twiddle ROM port (1-cycle ROM)
//   bf_en, bf_xin/yin/wr: butterfly operand strobe and operands
//   bf_valid, bf_xout/yout : butterfly results
//   wr_en, wr_addr_x/y, wr_data_x/y : coefficient RAM write-back port
// Build option
//   NTT_SCHED_PERF_EN   : adds cyc_cnt[31:0], a count of busy cycles of the
//                         most recent run (cleared on accepted start).
// ============================================================================
module ntt_stage_sched #(
   parameter int DW     = 33,
   parameter int LOGN   = 8,
   parameter int BF_LAT = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            rd_en,
   output logic [LOGN-1:0] rd_addr_x,
   output logic [LOGN-1:0] rd_addr_y,
   input  logic [DW-1:0]   rd_data_x,
   input  logic [DW-1:0]   rd_data_y,
   output logic [LOGN-2:0] tw_addr,
   input  logic [DW-1:0]   tw_data,
   output logic            bf_en,
   output logic [DW-1:0]   bf_xin,
   output logic [DW-1:0]   bf_yin,
   output logic [DW-1:0]   bf_wr,
   input  logic            bf_valid,
   input  logic [DW-1:0]   bf_xout,
   input  logic [DW-1:0]   bf_yout,
   output logic            wr_en,
   output logic [LOGN-1:0] wr_addr_x,
   output logic [LOGN-1:0] wr_addr_y,
   output logic [DW-1:0]   wr_data_x,
   output logic [DW-1:0]   wr_data_y
`ifdef NTT_SCHED_PERF_EN
   ,
   output logic [31:0]     cyc_cnt
`endif
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_SW  = (LOGN > 1) ? $clog2(LOGN) : 1;           // stage index width
   localparam int c_DL  = BF_LAT + 1;                              // write-back delay depth
   localparam int c_DCW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;   // drain counter width

   localparam logic [LOGN-2:0] c_B_LAST = '1;                      // N/2 - 1
   localparam logic [LOGN-2:0] c_B_ONE  = (LOGN-1)'(1);
   localparam logic [c_SW-1:0] c_S_LAST = c_SW'(LOGN - 1);
   localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);
   localparam logic [c_DCW-1:0] c_D_LAST = c_DCW'(BF_LAT);
   localparam logic [c_DCW-1:0] c_D_ONE  = c_DCW'(1);
   localparam logic [LOGN-1:0] c_A_ONE  = LOGN'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t           r_state;
   logic [c_SW-1:0]  r_s;        // stage of the pair currently on the read port
   logic [LOGN-2:0]  r_b;        // butterfly index of that pair
   logic [c_DCW-1:0] r_dcnt;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_rd_en;
   logic [LOGN-1:0]  r_rd_addr_x;
   logic [LOGN-1:0]  r_rd_addr_y;
   logic [LOGN-2:0]  r_tw_addr;
   logic             r_bf_en;

   // Write-back delay line: {tag, x address, y address} per issued pair.
   logic             r_dl_tag [c_DL];
   logic [LOGN-1:0]  r_dl_ax  [c_DL];
   logic [LOGN-1:0]  r_dl_ay  [c_DL];

   // ------------------------------------------------------------------------
   // Next-issue selection: which (s, b) goes onto the read port next cycle.
   // ------------------------------------------------------------------------
   logic             w_iss;
   logic [c_SW-1:0]  w_iss_s;
   logic [LOGN-2:0]  w_iss_b;

   always_comb begin
      w_iss   = 1'b0;
      w_iss_s = r_s;
      w_iss_b = r_b;
      case (r_state)
         ST_IDLE: begin
            w_iss   = start;
            w_iss_s = '0;
            w_iss_b = '0;
         end
         ST_ISSUE: begin
            w_iss   = (r_b != c_B_LAST);
            w_iss_b = r_b + c_B_ONE;
         end
         ST_DRAIN: begin
            // The first read of the next stage lands the cycle after the last
            // write-back of this one.
            w_iss   = (r_dcnt == c_D_LAST) && (r_s != c_S_LAST);
            w_iss_s = r_s + c_S_ONE;
            w_iss_b = '0;
         end
         default: begin
            w_iss = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Address generation for the selected pair.
   //   span = 2^(LOGN-1-s)
   //   x    = (b >> log2(span)) * 2*span + (b & (span-1)),  y = x + span
   //   tw   = (b & (span-1)) << s
   // The group index is placed one bit higher than it sits in b, which is the
   // "insert a zero at bit position log2(span)" view of the same formula.
   // ------------------------------------------------------------------------
   int              w_sh;
   logic [LOGN-1:0] w_bx;
   logic [LOGN-1:0] w_span;
   logic [LOGN-1:0] w_lo;
   logic [LOGN-1:0] w_ax;
   logic [LOGN-1:0] w_ay;
   logic [LOGN-2:0] w_tw;

   always_comb begin
      w_sh   = (LOGN - 1) - int'(w_iss_s);
      w_bx   = {1'b0, w_iss_b};
      w_span = c_A_ONE << w_sh;
      w_lo   = w_bx & (w_span - c_A_ONE);
      w_ax   = ((w_bx >> w_sh) << (w_sh + 1)) | w_lo;
      w_ay   = w_ax + w_span;
      // w_lo < span, so shifting by s stays below 2^(LOGN-1): truncation is lossless.
      w_tw   = (LOGN-1)'(w_lo << w_iss_s);
   end

   // ------------------------------------------------------------------------
   // Write-back side
   // ------------------------------------------------------------------------
   logic w_tail_tag;
   logic w_wr_en;
   logic w_orphan;

   assign w_tail_tag = r_dl_tag[c_DL-1];
   assign w_wr_en    = bf_valid & w_tail_tag;
   assign w_orphan   = bf_valid & ~w_tail_tag;

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_s         <= '0;
         r_b         <= '0;
         r_dcnt      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr_x <= '0;
         r_rd_addr_y <= '0;
         r_tw_addr   <= '0;
         r_bf_en     <= 1'b0;
      end else begin
         r_rd_en     <= w_iss;
         r_rd_addr_x <= w_iss ? w_ax : '0;
         r_rd_addr_y <= w_iss ? w_ay : '0;
         r_tw_addr   <= w_iss ? w_tw : '0;
         // RAM and ROM data arrive one cycle after the read strobe.
         r_bf_en     <= r_rd_en;

         if (w_iss) begin
            r_s <= w_iss_s;
            r_b <= w_iss_b;
         end

         if (w_orphan) begin
            r_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_ISSUE;
                  r_busy  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (r_b == c_B_LAST) begin
                  r_state <= ST_DRAIN;
                  r_dcnt  <= '0;
               end
            end
            ST_DRAIN: begin
               if (r_dcnt == c_D_LAST) begin
                  if (r_s == c_S_LAST) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end else begin
                  r_dcnt <= r_dcnt + c_D_ONE;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Write-back delay line. Entries are pushed every cycle; non-read cycles
   // push a zero tag so the tail tells whether a result is expected.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_DL; i++) begin
            r_dl_tag[i] <= 1'b0;
            r_dl_ax[i]  <= '0;
            r_dl_ay[i]  <= '0;
         end
      end else begin
         r_dl_tag[0] <= r_rd_en;
         r_dl_ax[0]  <= r_rd_addr_x;
         r_dl_ay[0]  <= r_rd_addr_y;
         for (int i = 1; i < c_DL; i++) begin
            r_dl_tag[i] <= r_dl_tag[i-1];
            r_dl_ax[i]  <= r_dl_ax[i-1];
            r_dl_ay[i]  <= r_dl_ay[i-1];
         end
      end
   end

`ifdef NTT_SCHED_PERF_EN
   // ------------------------------------------------------------------------
   // Busy-cycle counter for the most recent run; holds after done.
   // ------------------------------------------------------------------------
   logic [31:0] r_cyc_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc_cnt <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_cyc_cnt <= '0;
      end else if (r_busy) begin
         r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
   end

   assign cyc_cnt = r_cyc_cnt;
`endif

   // ------------------------------------------------------------------------
   // Outputs. The data paths are combinational pass-throughs, gated by their
   // strobes so that every data output reads zero whenever it is not valid,
   // including immediately on reset.
   // ------------------------------------------------------------------------
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign rd_en     = r_rd_en;
   assign rd_addr_x = r_rd_addr_x;
   assign rd_addr_y = r_rd_addr_y;
   assign tw_addr   = r_tw_addr;
   assign bf_en     = r_bf_en;
   assign bf_xin    = r_bf_en ? rd_data_x : '0;
   assign bf_yin    = r_bf_en ? rd_data_y : '0;
   assign bf_wr     = r_bf_en ? tw_data   : '0;
   assign wr_en     = w_wr_en;
   assign wr_addr_x = r_dl_ax[c_DL-1];
   assign wr_addr_y = r_dl_ay[c_DL-1];
   assign wr_data_x = w_wr_en ? bf_xout : '0;
   assign wr_data_y = w_wr_en ? bf_yout : '0;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_stage_sched
// Purpose  : Self-checking bench for ntt_stage_sched with LOGN=3, BF_LAT=5.
//            Provides a coefficient RAM, a twiddle ROM (100 + address) and a
//            butterfly returning x+y / x-y after BF_LAT cycles. Expected
//            read/write schedules and data are hand-computed tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_sched;

   localparam int DW     = 33;
   localparam int LOGN   = 3;
   localparam int BF_LAT = 5;
   localparam int N      = 1 << LOGN;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            busy, done, err, rd_en, bf_en, bf_valid, wr_en;
   logic [LOGN-1:0] rd_addr_x, rd_addr_y, wr_addr_x, wr_addr_y;
   logic [LOGN-2:0] tw_addr;
   logic [DW-1:0]   rd_data_x, rd_data_y, tw_data;
   logic [DW-1:0]   bf_xin, bf_yin, bf_wr, bf_xout, bf_yout;
   logic [DW-1:0]   wr_data_x, wr_data_y;
`ifdef NTT_SCHED_PERF_EN
   logic [31:0]     cyc_cnt;
`endif

   logic            load = 1'b0;
   logic            force_v = 1'b0;

   always #5 clk = ~clk;

   ntt_stage_sched #(.DW(DW), .LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .busy(busy), .done(done), .err(err),
      .rd_en(rd_en), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
      .rd_data_x(rd_data_x), .rd_data_y(rd_data_y),
      .tw_addr(tw_addr), .tw_data(tw_data),
      .bf_en(bf_en), .bf_xin(bf_xin), .bf_yin(bf_yin), .bf_wr(bf_wr),
      .bf_valid(bf_valid), .bf_xout(bf_xout), .bf_yout(bf_yout),
      .wr_en(wr_en), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y),
      .wr_data_x(wr_data_x), .wr_data_y(wr_data_y)
`ifdef NTT_SCHED_PERF_EN
      , .cyc_cnt(cyc_cnt)
`endif
   );

   // ------------------------------------------------------------------------
   // Environment: RAM, twiddle ROM, butterfly
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem [N];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < N; i++) mem[i] <= DW'(i + 1);
      end else if (wr_en) begin
         mem[wr_addr_x] <= wr_data_x;
         mem[wr_addr_y] <= wr_data_y;
      end
      if (rd_en) begin
         rd_data_x <= mem[rd_addr_x];
         rd_data_y <= mem[rd_addr_y];
      end
      tw_data <= DW'(100) + DW'(tw_addr);
   end

   logic          p_v [BF_LAT];
   logic [DW-1:0] p_x [BF_LAT];
   logic [DW-1:0] p_y [BF_LAT];

   always @(posedge clk) begin
      p_v[0] <= bf_en;
      p_x[0] <= bf_xin + bf_yin;
      p_y[0] <= bf_xin - bf_yin;
      for (int i = 1; i < BF_LAT; i++) begin
         p_v[i] <= p_v[i-1];
         p_x[i] <= p_x[i-1];
         p_y[i] <= p_y[i-1];
      end
   end

   assign bf_valid = p_v[BF_LAT-1] | force_v;
   assign bf_xout  = p_x[BF_LAT-1];
   assign bf_yout  = p_y[BF_LAT-1];

   // ------------------------------------------------------------------------
   // Expected schedules
   // ------------------------------------------------------------------------
   typedef struct { int cyc; int ax; int ay; int tw; } rd_vec_t;
   typedef struct { int cyc; int ax; int ay; int dx; int dy; } wr_vec_t;

   rd_vec_t rtab [12];
   wr_vec_t wtab [12];
   int      fexp [N];

   int n_cmp = 0;
   int n_bad = 0;

   // Per-cycle samples of one run
   logic            s_rd_en [64], s_bf_en [64], s_wr_en [64];
   logic            s_busy [64], s_done [64], s_err [64];
   logic [LOGN-1:0] s_ax [64], s_ay [64], s_wax [64], s_way [64];
   logic [LOGN-2:0] s_tw [64];
   logic [DW-1:0]   s_xin [64], s_yin [64], s_wr [64], s_wdx [64], s_wdy [64];
   logic [31:0]     s_cyc [64];

   function automatic logic [DW-1:0] to_dw(input int v);
      return DW'(v);
   endfunction

   function automatic bit in_rtab(input int c);
      for (int i = 0; i < 12; i++) if (rtab[i].cyc == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit in_wtab(input int c);
      for (int i = 0; i < 12; i++) if (wtab[i].cyc == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, c, act, exp);
      end
   endtask

   // All outputs must be zero (reset state).
   task automatic chk_quiet(input int c);
      chk("q_busy", c, 64'(busy), 64'd0);
      chk("q_done", c, 64'(done), 64'd0);
      chk("q_err", c, 64'(err), 64'd0);
      chk("q_rd_en", c, 64'(rd_en), 64'd0);
      chk("q_rd_addr_x", c, 64'(rd_addr_x), 64'd0);
      chk("q_rd_addr_y", c, 64'(rd_addr_y), 64'd0);
      chk("q_tw_addr", c, 64'(tw_addr), 64'd0);
      chk("q_bf_en", c, 64'(bf_en), 64'd0);
      chk("q_bf_xin", c, 64'(bf_xin), 64'd0);
      chk("q_wr_en", c, 64'(wr_en), 64'd0);
      chk("q_wr_addr_x", c, 64'(wr_addr_x), 64'd0);
      chk("q_wr_addr_y", c, 64'(wr_addr_y), 64'd0);
      chk("q_wr_data_x", c, 64'(wr_data_x), 64'd0);
`ifdef NTT_SCHED_PERF_EN
      chk("q_cyc_cnt", c, 64'(cyc_cnt), 64'd0);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic do_load();
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Called at #1 after an edge: that cycle is cycle 0, start is raised in it.
   task automatic run_capture(input int n, input int pulse2, input int fv_cyc);
      for (int k = 0; k < n; k++) begin
         start   = (k == 0) || (k == pulse2);
         force_v = (k == fv_cyc);
         @(negedge clk);
         s_rd_en[k] = rd_en;   s_ax[k] = rd_addr_x;  s_ay[k] = rd_addr_y;
         s_tw[k]    = tw_addr; s_bf_en[k] = bf_en;   s_xin[k] = bf_xin;
         s_yin[k]   = bf_yin;  s_wr[k] = bf_wr;      s_busy[k] = busy;
         s_done[k]  = done;    s_err[k] = err;       s_wr_en[k] = wr_en;
         s_wax[k]   = wr_addr_x; s_way[k] = wr_addr_y;
         s_wdx[k]   = wr_data_x; s_wdy[k] = wr_data_y;
`ifdef NTT_SCHED_PERF_EN
         s_cyc[k]   = cyc_cnt;
`else
         s_cyc[k]   = 32'd0;
`endif
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      force_v = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rtab[0]  = '{1, 0, 4, 0};  rtab[1]  = '{2, 1, 5, 1};
      rtab[2]  = '{3, 2, 6, 2};  rtab[3]  = '{4, 3, 7, 3};
      rtab[4]  = '{11, 0, 2, 0}; rtab[5]  = '{12, 1, 3, 2};
      rtab[6]  = '{13, 4, 6, 0}; rtab[7]  = '{14, 5, 7, 2};
      rtab[8]  = '{21, 0, 1, 0}; rtab[9]  = '{22, 2, 3, 0};
      rtab[10] = '{23, 4, 5, 0}; rtab[11] = '{24, 6, 7, 0};

      // RAM starts as 1..8; butterfly is x+y / x-y
      wtab[0]  = '{7, 0, 4, 6, -4};    wtab[1]  = '{8, 1, 5, 8, -4};
      wtab[2]  = '{9, 2, 6, 10, -4};   wtab[3]  = '{10, 3, 7, 12, -4};
      wtab[4]  = '{17, 0, 2, 16, -4};  wtab[5]  = '{18, 1, 3, 20, -4};
      wtab[6]  = '{19, 4, 6, -8, 0};   wtab[7]  = '{20, 5, 7, -8, 0};
      wtab[8]  = '{27, 0, 1, 36, -4};  wtab[9]  = '{28, 2, 3, -8, 0};
      wtab[10] = '{29, 4, 5, -16, 0};  wtab[11] = '{30, 6, 7, 0, 0};

      fexp = '{36, -4, -8, 0, -16, 0, 0, 0};

      // ---------------- Reset state ----------------
      do_reset();
      @(negedge clk);
      chk_quiet(-1);
      @(posedge clk); #1;

      // ---------------- Run A: full run, stray start at cycle 5 ----------------
      do_load();
      run_capture(41, 5, -1);
      for (int k = 0; k < 41; k++) begin
         chk("rd_en", k, 64'(s_rd_en[k]), 64'(in_rtab(k)));
         chk("bf_en", k, 64'(s_bf_en[k]), 64'((k > 0) && in_rtab(k - 1)));
         chk("wr_en", k, 64'(s_wr_en[k]), 64'(in_wtab(k)));
         chk("busy", k, 64'(s_busy[k]), 64'((k >= 1) && (k <= 31)));
         chk("done", k, 64'(s_done[k]), 64'(k == 31));
         chk("err", k, 64'(s_err[k]), 64'd0);
      end
      for (int i = 0; i < 12; i++) begin
         chk("rd_addr_x", rtab[i].cyc, 64'(s_ax[rtab[i].cyc]), 64'(rtab[i].ax));
         chk("rd_addr_y", rtab[i].cyc, 64'(s_ay[rtab[i].cyc]), 64'(rtab[i].ay));
         chk("tw_addr", rtab[i].cyc, 64'(s_tw[rtab[i].cyc]), 64'(rtab[i].tw));
         chk("wr_addr_x", wtab[i].cyc, 64'(s_wax[wtab[i].cyc]), 64'(wtab[i].ax));
         chk("wr_addr_y", wtab[i].cyc, 64'(s_way[wtab[i].cyc]), 64'(wtab[i].ay));
         chk("wr_data_x", wtab[i].cyc, 64'(s_wdx[wtab[i].cyc]), 64'(to_dw(wtab[i].dx)));
         chk("wr_data_y", wtab[i].cyc, 64'(s_wdy[wtab[i].cyc]), 64'(to_dw(wtab[i].dy)));
      end
      for (int k = 2; k <= 5; k++) begin
         chk("bf_xin", k, 64'(s_xin[k]), 64'(k - 1));
         chk("bf_yin", k, 64'(s_yin[k]), 64'(k + 3));
         chk("bf_wr", k, 64'(s_wr[k]), 64'(98 + k));
      end
      for (int i = 0; i < N; i++) chk("final_mem", i, 64'(mem[i]), 64'(to_dw(fexp[i])));
`ifdef NTT_SCHED_PERF_EN
      chk("cyc_cnt_start", 1, 64'(s_cyc[1]), 64'd0);
      chk("cyc_cnt_end", 40, 64'(s_cyc[40]), 64'd31);
`endif

      // ---------------- Run B: orphan bf_valid at cycle 3 ----------------
      do_reset();
      do_load();
      run_capture(36, -1, 3);
      chk("orphan_wr_en", 3, 64'(s_wr_en[3]), 64'd0);
      chk("orphan_err_pre", 3, 64'(s_err[3]), 64'd0);
      chk("orphan_err", 4, 64'(s_err[4]), 64'd1);
      chk("orphan_err_sticky", 35, 64'(s_err[35]), 64'd1);
      chk("orphan_wr_normal", 7, 64'(s_wr_en[7]), 64'd1);
      chk("orphan_done", 31, 64'(s_done[31]), 64'd1);
      do_reset();
      @(negedge clk);
      chk("err_cleared", 0, 64'(err), 64'd0);
      @(posedge clk); #1;

      // ---------------- Run C: reset at cycle 14 ----------------
      do_load();
      run_capture(14, -1, -1);
      reset = 1'b1;
      #1;
      chk_quiet(14);
      // Hold reset while the in-flight stage-1 results (cycles 17, 18) drain.
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_err", 0, 64'(err), 64'd0);
      chk("post_rst_busy", 0, 64'(busy), 64'd0);
      chk("post_rst_rd_en", 0, 64'(rd_en), 64'd0);
      @(posedge clk); #1;
      do_load();
      run_capture(36, -1, -1);
      for (int k = 0; k <= 12; k++) begin
         chk("c_rd_en", k, 64'(s_rd_en[k]), 64'(in_rtab(k)));
      end
      for (int i = 0; i < 4; i++) begin
         chk("c_rd_addr_x", rtab[i].cyc, 64'(s_ax[rtab[i].cyc]), 64'(rtab[i].ax));
         chk("c_rd_addr_y", rtab[i].cyc, 64'(s_ay[rtab[i].cyc]), 64'(rtab[i].ay));
         chk("c_tw_addr", rtab[i].cyc, 64'(s_tw[rtab[i].cyc]), 64'(rtab[i].tw));
      end
      chk("c_done30", 30, 64'(s_done[30]), 64'd0);
      chk("c_done31", 31, 64'(s_done[31]), 64'd1);
      chk("c_busy32", 32, 64'(s_busy[32]), 64'd0);
      chk("c_err", 35, 64'(s_err[35]), 64'd0);
`ifdef NTT_SCHED_PERF_EN
      chk("c_cyc_cnt", 35, 64'(s_cyc[35]), 64'd31);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ntt_stage_sched.md
Name: ntt_stage_sched

Overview:
- Upstream scheduler and write-back sequencer for the pipelined radix-2 NTT butterfly.
- Walks all LOGN Cooley-Tukey stages over an N=2^LOGN coefficient RAM.
- Issues read addresses and twiddle addresses, presents operand pairs to the butterfly with `bf_en`, and writes butterfly results back in place.
- Drains the butterfly pipeline between stages; pulses `done` when the transform is complete.

Parameters:
- DW, 33: coefficient/twiddle width (matches the butterfly's `Datawidth+1).
- LOGN, 8: log2 of transform length N.
- BF_LAT, 5: fixed cycles from butterfly `en` to its `valid`.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full NTT.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky: `bf_valid` arrived with no matching issued pair.
- rd_en  out  1  coefficient RAM read strobe; data is returned 1 cycle later.
- rd_addr_x  out  LOGN  x-operand address.
- rd_addr_y  out  LOGN  y-operand address.
- rd_data_x  in  DW  x data.
- rd_data_y  in  DW  y data.
- tw_addr  out  LOGN-1  twiddle ROM address (1-cycle ROM).
- tw_data  in  DW  twiddle.
- bf_en  out  1  butterfly operand strobe.
- bf_xin  out  DW  butterfly x operand.
- bf_yin  out  DW  butterfly y operand.
- bf_wr  out  DW  butterfly twiddle operand.
- bf_valid  in  1  butterfly result strobe.
- bf_xout  in  DW  butterfly x result.
- bf_yout  in  DW  butterfly y result.
- wr_en  out  1  write strobe.
- wr_addr_x  out  LOGN  write address for x result.
- wr_addr_y  out  LOGN  write address for y result.
- wr_data_x  out  DW  x result.
- wr_data_y  out  DW  y result.

Behaviour:
- Reset: state IDLE; stage and butterfly counters 0; delay line cleared; `busy`, `done`, `err`, `rd_en`, `bf_en`, `wr_en` = 0; all address/data outputs 0.
- States:
  - IDLE: on `start`, go to ISSUE, s=0, b=0.
  - ISSUE: one pair per cycle, `rd_en`=1.
    - span = 2^(LOGN-1-s).
    - rd_addr_x = (b>>(LOGN-1-s))·2·span + (b & (span-1)); rd_addr_y = rd_addr_x + span.
    - tw_addr = (b & (span-1)) << s.
    - b counts 0..N/2-1; after b=N/2-1, go to DRAIN.
  - DRAIN: wait until the last write of stage s completes, i.e. BF_LAT+1 cycles after the final issue. Then, if s<LOGN-1: s++, b=0, go to ISSUE. Otherwise go to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- Handshakes:
  - `start` is ignored unless the state is IDLE.
  - `busy` is 1 in ISSUE, DRAIN and FIN.
- Operand path: `bf_en` is `rd_en` delayed 1 cycle. `bf_xin`/`bf_yin`/`bf_wr` pass through `rd_data_x`/`rd_data_y`/`tw_data` combinationally.
- Write-back:
  - The address pair plus a tag bit enter a delay line of depth BF_LAT+1 at `rd_en`.
  - `wr_en` = `bf_valid`; `wr_addr` comes from the delay line tail; `wr_data` = `bf_xout`/`bf_yout` combinationally.
  - If `bf_valid`=1 while the tail tag is 0: suppress `wr_en` and set `err` (cleared only by reset).
- Stage period: N/2 + 1 + BF_LAT cycles.
- Total latency: from the `start` edge to the `done` pulse is LOGN·(N/2+1+BF_LAT)+1 cycles.
- Stage boundary: no read of stage s+1 may occur in the same cycle as, or before, the last write of stage s.
- Reset mid-operation: immediate return to the reset state. In-flight butterfly results arriving afterwards with tag 0 set `err` only if they arrive after reset is released.
- Widths: address arithmetic is done in LOGN bits with no wrap. rd_addr_y ≤ N-1 always holds by construction.

Optional Feature:
- Macro: NTT_SCHED_PERF_EN.
- Defined: adds output `cyc_cnt` [31:0]. It clears on accepted `start`, increments every busy cycle, holds after `done`, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LOGN=3, BF_LAT=5, `start` at cycle 0 → stage 0 rd pairs (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3 in cycles 1-4; `bf_en` in cycles 2-5.
- Same run, stage 1 → pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2, first `rd_en` at cycle 11. Stage 2 → pairs (0,1)(2,3)(4,5)(6,7), tw 0, first `rd_en` at cycle 21. `done` at cycle 31; `busy` is high in cycles 1-31.
- Butterfly model returns x+y / x-y with latency 5 → `wr_en` in cycles 7-10. The written addresses equal the read pairs. No `rd_en` occurs before cycle 11.
- `start` pulsed at cycle 5 during the run → ignored; `done` still at 31, and no second run.
- `bf_valid` forced high at cycle 3 → no `wr_en`, `err`=1 and stays 1 until reset.
- `reset` asserted at cycle 14 → all outputs 0 in the same cycle. A new `start` after release produces the cycle-0 sequence. With NTT_SCHED_PERF_EN, `cyc_cnt`=31 after a full uninterrupted run.
